tx_uart: RTL
============

TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 tx_enable_signal  input  1  high: transmitter may launch new frames.
REQ-005 tx_start  input  1  write strobe; one byte accepted per cycle when tx_start & tx_ready.
REQ-006 tx_data  input  8  byte to send; sampled on the accepting cycle only.
REQ-007 tx_ready  output  1  high when the one-byte holding register is empty.
REQ-008 tx_busy  output  1  high while a frame is on the line (state != IDLE).
REQ-009 tx_done_signal  output  1  one-cycle pulse at the end of each stop bit.
REQ-010 tx_out  output  1  serial line, idle high.

Function
REQ-011 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 Datapath SHALL be a one-byte holding register (hold_data, hold_valid) feeding a shift register; tx_ready = ~hold_valid.
REQ-013 tx_start while tx_ready is low SHALL be ignored; holding register and line are unaffected.
REQ-014 tx_start with tx_ready high SHALL be accepted regardless of tx_enable_signal; the byte waits in the holding register.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START when hold_valid & tx_enable_signal; same edge loads shift register, clears hold_valid, clears baud counter.
REQ-017 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits (3-bit bit counter reaching 7 and baud counter at CLKS_PER_BIT-1); STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-018 Latency: byte accepted on edge N while IDLE with enable high -> hold_valid set on edge N, START entered on edge N+1, tx_out low from edge N+1.
REQ-019 tx_out SHALL be registered; no glitches; high in IDLE and STOP.
REQ-020 Baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary.
REQ-021 tx_done_signal SHALL pulse on the cycle STOP completes (last stop-bit cycle), exactly once per frame.
REQ-022 Back-to-back: if hold_valid & tx_enable_signal at STOP completion, FSM SHALL go directly STOP -> START (no idle cycles); tx_done_signal still pulses.
REQ-023 Holding register SHALL be refillable as soon as it is transferred (REQ-016), i.e. during the frame in flight.
REQ-024 Simultaneous transfer-to-shift and new tx_start on one edge: tx_ready is low that cycle (hold_valid still 1), so the new strobe is ignored.
REQ-025 tx_enable_signal low mid-frame: current frame SHALL complete normally; no further launch until enable returns high.
REQ-026 tx_data changes outside the accepting cycle SHALL not affect the line.

Reset
REQ-027 On rst high, immediately and asynchronously: state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done_signal=0, hold_valid=0, all counters 0.
REQ-028 Reset mid-frame SHALL abort the frame (line returns high at once, no tx_done_signal) and discard any held byte.
REQ-029 After rst release, first accepted byte SHALL follow REQ-018 timing.

Verification (CLKS_PER_BIT=4)
REQ-030 tx_data=0x55, tx_start 1 cycle, enable=1 -> tx_out 0,1,0,1,0,1,0,1,0,1 each 4 cycles (start, LSB first, stop); tx_done_signal one pulse at cycle 40; tx_busy high 40 cycles.
REQ-031 Send 0xA3 then 0x0F with second strobe as soon as tx_ready rises -> 80 contiguous bit-cycles, no idle gap, two tx_done_signal pulses 40 cycles apart; decoded bytes 0xA3, 0x0F.
REQ-032 Held byte 0x12 pending, second strobe 0x34 while tx_ready=0 -> only 0x12 transmitted; 0x34 never appears.
REQ-033 enable=0, strobe 0x7E -> tx_ready=0, tx_out stays 1; raise enable -> start bit next edge, 0x7E sent.
REQ-034 rst asserted at cycle 17 of frame 0xC4 with byte 0x99 held -> tx_out=1 same cycle, no tx_done_signal, nothing sent after release until a new strobe.
REQ-035 Random bytes, random strobe gaps, random enable toggling, 1000 frames -> scoreboard via bit-sampling UART model matches input order exactly; no tx_done_signal without a full frame.

Source files
------------

// File: rtl/tx_uart.sv
// 8N1 UART transmitter: a one-byte holding register feeds a shift register,
// so the next byte can be queued while the current frame is on the line.
//
// state | meaning
// IDLE  | line high, waiting for a held byte and tx_enable_signal
// START | start bit (0) on the line
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); may hand straight over to START for back-to-back frames
module tx_uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable_signal,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done_signal,
  output logic       tx_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic        tx_out_q, tx_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        launch;

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    tx_out_d     = tx_out_q;
    bit_end      = (baud_q == BAUD_LAST);
    launch       = 1'b0;

    if (tx_start && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end

    if (state_q != IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      IDLE: launch = hold_valid_q && tx_enable_signal;
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          tx_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            tx_out_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            tx_out_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          launch  = hold_valid_q && tx_enable_signal;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transfer empties the holding register; a strobe this cycle sees tx_ready low.
    if (launch) begin
      state_d      = START;
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      baud_d       = 16'd0;
      bit_d        = 3'd0;
      tx_out_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (baud_q == BAUD_PRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      hold_data_q  <= 8'd0;
      hold_valid_q <= 1'b0;
      tx_out_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_out_q     <= tx_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx_ready       = ~hold_valid_q;
  assign tx_busy        = busy_q;
  assign tx_done_signal = done_q;
  assign tx_out         = tx_out_q;

endmodule
